// File: rtl/ilt_pkg.sv
// ilt_pkg: shared constants and FSM state type for the inverter loopback tester
package ilt_pkg;
  localparam int LFSR_W = 8;
  localparam int MAX_LAT = 7;
  localparam int ERR_W = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DL_DEPTH = MAX_LAT + 3;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'h1D;
  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;
endpackage

// File: rtl/inverter_loopback_tester_if.sv
// inverter_loopback_tester_if: run control, analog pins and result readout
// master drives start/len/lat_sel/expect_inv and the returned rx_in bit;
// slave (the tester) drives tx_out, busy, done, pass and err_cnt.
interface inverter_loopback_tester_if;
  logic start;
  logic [7:0] len;
  logic [2:0] lat_sel;
  logic expect_inv;
  logic rx_in;
  logic tx_out;
  logic busy;
  logic done;
  logic pass;
  logic [ilt_pkg::ERR_W-1:0] err_cnt;
  modport master (output start, len, lat_sel, expect_inv, rx_in, input tx_out, busy, done, pass, err_cnt);
  modport slave (input start, len, lat_sel, expect_inv, rx_in, output tx_out, busy, done, pass, err_cnt);
endinterface

// File: rtl/ilt_lfsr.sv
// ilt_lfsr: Fibonacci right-shift LFSR stimulus source
// ports: clk, rst (sync), load (reseed), en (advance), tx_bit (current l[0])
module ilt_lfsr
  import ilt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tx_bit
);
  logic [LFSR_W-1:0] l;
  always_ff @(posedge clk)
    if (rst || load) l <= LFSR_SEED;
    else if (en) l <= {^(l & LFSR_TAPS), l[LFSR_W-1:1]};
  assign tx_bit = l[0];
endmodule

// File: rtl/inverter_loopback_tester.sv
// inverter_loopback_tester: drives a PRBS into the analog inverter and checks the returned bits
// ports: clk, rst (sync, active high), bus (slave side of the run/pin/result interface)
module inverter_loopback_tester
  import ilt_pkg::*;
(
  input logic clk,
  input logic rst,
  inverter_loopback_tester_if.slave bus
);
  state_t state;
  logic [7:0] cnt;
  logic [2:0] lat_q;
  logic inv_q;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic [DL_DEPTH-1:0] dl_v;
  logic [DL_DEPTH-1:0] dl_b;
  logic [3:0] tap;
  logic lfsr_bit;
  logic accept;
  logic sending;
  logic miss;
  logic tx;
  logic busy;
  logic done;
  logic [ERR_W-1:0] err_cnt;
  assign accept = state == IDLE && bus.start;
  assign sending = state == SEND;
  assign tap = 4'(lat_q) + 4'd2;
  assign miss = dl_v[tap] && (rx_sync[SYNC_STAGES-1] != dl_b[tap]);
  ilt_lfsr u_lfsr (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .en(sending),
    .tx_bit(lfsr_bit)
  );
  // busy is a registered copy of the run states so it rises and falls one
  // cycle after the FSM, lining up with the first tx bit and with done.
  // cnt counts transmitted bits in SEND and the drain wait in DRAIN.
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      lat_q <= '0;
      inv_q <= 1'b0;
      rx_sync <= '0;
      dl_v <= '0;
      dl_b <= '0;
      tx <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err_cnt <= '0;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], bus.rx_in};
      dl_v <= {dl_v[DL_DEPTH-2:0], sending};
      dl_b <= {dl_b[DL_DEPTH-2:0], sending && (lfsr_bit ^ inv_q)};
      tx <= sending && lfsr_bit;
      busy <= sending || state == DRAIN;
      done <= accept ? 1'b0 : (state == DONE || done);
      err_cnt <= accept ? '0 : (miss && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
      case (state)
        IDLE:
          if (bus.start) begin
            state <= bus.len == 8'd0 ? DONE : SEND;
            cnt <= bus.len;
            lat_q <= bus.lat_sel;
            inv_q <= bus.expect_inv;
          end
        SEND: begin
          state <= cnt == 8'd1 ? DRAIN : SEND;
          cnt <= cnt == 8'd1 ? {5'd0, lat_q} + 8'd1 : cnt - 8'd1;
        end
        DRAIN: begin
          state <= cnt == 8'd0 ? DONE : DRAIN;
          cnt <= cnt - 8'd1;
        end
        DONE: state <= IDLE;
      endcase
    end
  assign bus.tx_out = tx;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.err_cnt = err_cnt;
  assign bus.pass = done && err_cnt == '0;
endmodule
